// File: rtl/led_bar_scan.sv
// Multiplexed LED bar driver: one LED per clock, zero-centred bar plus decaying peak marker, with PWM dimming and blink.
// Outputs are registered one clock after the LED index is scanned; no backpressure, the scan never stalls.
module led_bar_scan #(
  parameter int ROWS        = 4,
  parameter int COLS        = 2,
  parameter int VAL_BITS    = 4,
  parameter int VAL_Z       = 3,
  parameter int PWM_BITS    = 3,
  parameter int HOLD_FRAMES = 15,
  parameter int BLINK_ON    = 2,
  parameter int BLINK_OFF   = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [VAL_BITS-1:0] value,
  input  logic                load,
  input  logic                blink,
  input  logic [PWM_BITS-1:0] bright,
  input  logic                peak_en,
  output logic [ROWS-1:0]     in_en,
  output logic [COLS-1:0]     out_en,
  output logic                frame
);

  localparam int N   = ROWS * COLS;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int HW  = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam int BMX = (BLINK_ON > BLINK_OFF) ? BLINK_ON : BLINK_OFF;
  localparam int BW  = (BMX > 1) ? $clog2(BMX) : 1;

  localparam logic [IW-1:0]       IDX_LAST  = IW'(N - 1);
  localparam logic [RW-1:0]       ROW_LAST  = RW'(ROWS - 1);
  localparam logic [VAL_BITS-1:0] VAL_MAX   = VAL_BITS'(N - 1);
  localparam logic [VAL_BITS-1:0] VZ        = VAL_BITS'(VAL_Z);
  localparam logic [HW-1:0]       HOLD_INIT = HW'(HOLD_FRAMES);
  localparam logic [BW-1:0]       ON_LAST   = BW'(BLINK_ON - 1);
  localparam logic [BW-1:0]       OFF_LAST  = BW'(BLINK_OFF - 1);

  typedef enum logic {PH_ON, PH_OFF} phase_t;

  logic [IW-1:0]       idx_q, idx_d;
  logic [RW-1:0]       row_q, row_d;
  logic [CW-1:0]       col_q, col_d;
  logic [VAL_BITS-1:0] val_q, val_d;
  logic [VAL_BITS-1:0] peak_q, peak_d;
  logic [HW-1:0]       hold_q, hold_d;
  logic [PWM_BITS-1:0] pwm_q, pwm_d;
  phase_t              ph_q, ph_d;
  logic [BW-1:0]       bcnt_q, bcnt_d;
  logic [ROWS-1:0]     in_en_q, in_en_d;
  logic [COLS-1:0]     out_en_q, out_en_d;
  logic                frame_q, frame_d;

  logic                frame_end;
  logic [VAL_BITS-1:0] val_clamped;
  logic [VAL_BITS-1:0] idx_v;
  logic                peak_load;
  logic                bar_lit;
  logic                peak_lit;
  logic                visible;
  logic                lit;

  always_comb begin
    frame_end   = (idx_q == IDX_LAST);
    val_clamped = (value > VAL_MAX) ? VAL_MAX : value;
    peak_load   = load && (val_clamped > peak_q);
    idx_v       = VAL_BITS'(idx_q);

    // Scan position; row and column advance in lockstep with idx.
    idx_d = idx_q + IW'(1);
    row_d = row_q + RW'(1);
    col_d = col_q;
    if (frame_end) begin
      idx_d = '0;
      row_d = '0;
      col_d = '0;
    end else if (row_q == ROW_LAST) begin
      row_d = '0;
      col_d = col_q + CW'(1);
    end

    val_d = load ? val_clamped : val_q;

    // A rising load restarts the hold; otherwise the marker holds, then slides toward the bar.
    peak_d = peak_q;
    hold_d = hold_q;
    if (peak_load) begin
      peak_d = val_clamped;
      hold_d = HOLD_INIT;
    end else if (frame_end) begin
      if (hold_q != '0) begin
        hold_d = hold_q - HW'(1);
      end else if (peak_q > val_q) begin
        peak_d = peak_q - VAL_BITS'(1);
      end
    end

    pwm_d = frame_end ? pwm_q + PWM_BITS'(1) : pwm_q;

    ph_d   = ph_q;
    bcnt_d = bcnt_q;
    if (!blink) begin
      ph_d   = PH_ON;
      bcnt_d = '0;
    end else if (frame_end) begin
      case (ph_q)
        PH_ON: begin
          if (bcnt_q == ON_LAST) begin
            ph_d   = PH_OFF;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
        default: begin
          if (bcnt_q == OFF_LAST) begin
            ph_d   = PH_ON;
            bcnt_d = '0;
          end else begin
            bcnt_d = bcnt_q + BW'(1);
          end
        end
      endcase
    end

    // Bar spans from the zero LED toward the value in either direction.
    if (val_q >= VZ) begin
      bar_lit = (idx_v >= VZ) && (idx_v <= val_q);
    end else begin
      bar_lit = (idx_v >= val_q) && (idx_v <= VZ);
    end
    peak_lit = peak_en && (idx_v == peak_q);
    visible  = en && (bright > pwm_q) && (!blink || (ph_q == PH_ON));
    lit      = visible && (bar_lit || peak_lit);

    in_en_d  = lit ? (ROWS'(1) << row_q) : '0;
    out_en_d = lit ? (COLS'(1) << col_q) : '0;
    frame_d  = frame_end;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q    <= '0;
      row_q    <= '0;
      col_q    <= '0;
      val_q    <= '0;
      peak_q   <= '0;
      hold_q   <= '0;
      pwm_q    <= '0;
      ph_q     <= PH_ON;
      bcnt_q   <= '0;
      in_en_q  <= '0;
      out_en_q <= '0;
      frame_q  <= 1'b0;
    end else begin
      idx_q    <= idx_d;
      row_q    <= row_d;
      col_q    <= col_d;
      val_q    <= val_d;
      peak_q   <= peak_d;
      hold_q   <= hold_d;
      pwm_q    <= pwm_d;
      ph_q     <= ph_d;
      bcnt_q   <= bcnt_d;
      in_en_q  <= in_en_d;
      out_en_q <= out_en_d;
      frame_q  <= frame_d;
    end
  end

  assign in_en  = in_en_q;
  assign out_en = out_en_q;
  assign frame  = frame_q;

endmodule
